// File: rtl/mic_peak_meter.sv
// Microphone peak meter: windowed peak detection with 1-step-per-window decay,
// thermometer LED bar and a two-digit multiplexed seven-segment readout.
module mic_peak_meter #(
  parameter int unsigned WINDOW      = 2000,
  parameter int unsigned OFFSET      = 2048,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        samp_tick,
  input  logic [11:0] sample,
  input  logic        hold,
  output logic [3:0]  level,
  output logic        level_valid,
  output logic [15:0] led,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int unsigned CW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic {DIG_ONES, DIG_TENS} digit_e;

  logic          s1_q, s2_q, s3_q;
  logic          acc_q;
  logic [11:0]   samp_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [11:0]   peak_q, peak_d;
  logic [3:0]    level_q, level_d;
  logic          upd_q, upd_d;
  logic          valid_q;
  logic [15:0]   led_q, led_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  digit_e        dig_q, dig_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  logic [11:0]   mag, pk_max, lvl_full;
  logic [3:0]    new_lvl, decayed, ones;
  logic          tens;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // Window accumulation and level update, driven by the registered accept strobe.
  always_comb begin
    mag      = (samp_q > 12'(OFFSET)) ? samp_q - 12'(OFFSET) : '0;
    pk_max   = (mag > peak_q) ? mag : peak_q;
    lvl_full = pk_max >> 7;
    new_lvl  = (lvl_full > 12'd15) ? 4'd15 : lvl_full[3:0];
    decayed  = (level_q == 4'd0) ? 4'd0 : level_q - 4'd1;
    cnt_d    = cnt_q;
    peak_d   = peak_q;
    level_d  = level_q;
    upd_d    = 1'b0;
    if (acc_q) begin
      if (cnt_q == CW'(WINDOW - 1)) begin
        cnt_d  = '0;
        peak_d = '0;
        if (!hold) begin
          level_d = (new_lvl > decayed) ? new_lvl : decayed;
          upd_d   = 1'b1;
        end
      end else begin
        cnt_d  = cnt_q + 1'b1;
        peak_d = pk_max;
      end
    end
  end

  always_comb begin
    led_d = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      led_d[i] = (i < 32'(level_q));
    end
  end

  // Display multiplexing; an and seg are both derived from dig_q so they stay in step.
  always_comb begin
    tens   = (level_q >= 4'd10);
    ones   = tens ? level_q - 4'd10 : level_q;
    rcnt_d = rcnt_q + 1'b1;
    dig_d  = dig_q;
    if (rcnt_q == RW'(REFRESH_DIV - 1)) begin
      rcnt_d = '0;
      dig_d  = (dig_q == DIG_ONES) ? DIG_TENS : DIG_ONES;
    end
    if (dig_q == DIG_ONES) begin
      an_d  = 4'b1110;
      seg_d = seg7(ones);
    end else begin
      an_d  = 4'b1101;
      seg_d = tens ? seg7(4'd1) : 7'h7F;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      acc_q   <= 1'b0;
      samp_q  <= '0;
      cnt_q   <= '0;
      peak_q  <= '0;
      level_q <= '0;
      upd_q   <= 1'b0;
      valid_q <= 1'b0;
      led_q   <= '0;
      rcnt_q  <= '0;
      dig_q   <= DIG_ONES;
      an_q    <= 4'b1111;
      seg_q   <= 7'h7F;
    end else begin
      s1_q    <= samp_tick;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      acc_q   <= s2_q & ~s3_q;
      if (s2_q & ~s3_q) samp_q <= sample;
      cnt_q   <= cnt_d;
      peak_q  <= peak_d;
      level_q <= level_d;
      upd_q   <= upd_d;
      valid_q <= upd_q;
      led_q   <= led_d;
      rcnt_q  <= rcnt_d;
      dig_q   <= dig_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign level       = level_q;
  assign level_valid = valid_q;
  assign led         = led_q;
  assign an          = an_q;
  assign seg         = seg_q;

endmodule

// File: doc/mic_peak_meter.md
MIC_PEAK_METER -- requirements
Module: mic_peak_meter

Interface
REQ-001 The block SHALL have the parameter WINDOW, default 2000, giving the number of accepted samples per measurement window (0.1 s at 20 kHz).
REQ-002 The block SHALL have the parameter OFFSET, default 2048, giving the mic zero-signal midpoint in sample codes.
REQ-003 The block SHALL have the parameter REFRESH_DIV, default 50000, giving the number of sys_clk cycles per seven-segment digit slot.
REQ-004 The block SHALL have port sys_clk, input, 1 bit: the sole clock, 100 MHz, with all state on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port samp_tick, input, 1 bit: level sample clock (clk20k domain), asynchronous to sys_clk.
REQ-007 The block SHALL have port sample, input, 12 bits: unsigned microphone sample (MIC_IN).
REQ-008 The block SHALL have port hold, input, 1 bit: freeze the displayed level when high (switch).
REQ-009 The block SHALL have port level, output, 4 bits: displayed volume level, 0..15.
REQ-010 The block SHALL have port level_valid, output, 1 bit: one-cycle pulse when level updates.
REQ-011 The block SHALL have port led, output, 16 bits: thermometer bar of level.
REQ-012 The block SHALL have port an, output, 4 bits: seven-segment anodes, active low.
REQ-013 The block SHALL have port seg, output, 7 bits: segments {g..a}, active low.

Function
REQ-014 samp_tick SHALL pass through a 2-flop synchronizer, and a rising edge of the synchronized signal SHALL produce a one-cycle accept strobe 3 cycles after the input edge; sample SHALL be captured on the accept strobe.
REQ-015 Magnitude SHALL be computed as sample-OFFSET when sample>OFFSET, else 0, in 12 bits unsigned.
REQ-016 A sample counter SHALL count accepted samples 0..WINDOW-1 and wrap to 0, and a running peak register SHALL hold the maximum magnitude within the current window.
REQ-017 On the accept strobe where the counter equals WINDOW-1 (window end), new_level SHALL be min(15, max(peak, current magnitude)>>7), and the running peak SHALL clear to 0 on the same edge.
REQ-018 At window end with hold=0, the displayed level SHALL become max(new_level, level-1), saturating at 0 (peak hold with 1-step decay per window).
REQ-019 level_valid SHALL pulse high for exactly one cycle, the cycle after the level register updates, and only at window end with hold=0.
REQ-020 When hold=1, level and led SHALL stay frozen and level_valid SHALL stay 0, while peak tracking and window counting continue; release SHALL take effect at the next window end.
REQ-021 led[i] SHALL be 1 iff i<level, so level 0 lights no LEDs and level 15 lights led[14:0] with led[15]=0; led SHALL be registered and track level with one cycle of lag.
REQ-022 The display SHALL show level as two decimal digits: an[0] shows the ones digit, an[1] shows the tens digit (blank when the tens digit is 0), and an[3:2] SHALL be held high.
REQ-023 A refresh counter SHALL count 0..REFRESH_DIV-1, the active digit SHALL toggle on wrap, and exactly one anode SHALL be low at any time outside reset.
REQ-024 seg SHALL be registered and consistent with an in the same cycle, using the 0-9 patterns 0x40,0x79,0x24,0x30,0x19,0x12,0x02,0x78,0x00,0x10 and blank 0x7F.
REQ-025 A samp_tick edge arriving in the same cycle as a refresh wrap SHALL be processed independently with no loss.
REQ-026 The logic SHALL contain no combinational paths from inputs to outputs.

Reset
REQ-027 When rst_n=0, all registers SHALL clear immediately: level=0, level_valid=0, led=0, an=4'b1111, seg=7'h7F, and the peak, sample counter, refresh counter and synchronizer SHALL all be 0.
REQ-028 Reset mid-window SHALL discard the partial window, and the first window after release SHALL span a full WINDOW accepted samples.
REQ-029 After rst_n deasserts, the first anode SHALL go low (an[0]) one cycle after release.

Verification
REQ-030 The bench SHALL drive WINDOW=4 with samples 2048,2300,2100,3000, hold=0 -> after the 4th strobe, peak=952, level=7, led=16'h007F, and level_valid pulses once.
REQ-031 The bench SHALL drive samples all <=2048 for one window after level=7 -> level=6, then 5 on the next window (decay), with led tracking.
REQ-032 The bench SHALL drive sample 4095 for one window -> level=15, led=16'h7FFF, display "15" (an[1] seg=0x79, an[0] seg=0x12).
REQ-033 The bench SHALL drive hold=1 and then a loud window -> level is unchanged and level_valid stays 0; after hold=0 the next window end updates level.
REQ-034 The bench SHALL assert rst_n low after 2 samples of a window and then release it -> outputs take reset values asynchronously, and the level update occurs only after 4 new strobes.
REQ-035 The bench SHALL drive REFRESH_DIV=8 with level=3 -> an alternates 1110/1101 every 8 cycles, the ones slot shows 0x30, and the tens slot shows 0x7F.
